// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store sequencer: state encodings,
// addressing-mode constants, watchdog limit and the pointer-clobber test.
package load_store_unit_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WB   = 2'd2;

   localparam logic [1:0] MODE_PLAIN   = 2'b00;
   localparam logic [1:0] MODE_POSTINC = 2'b01;
   localparam logic [1:0] MODE_PREDEC  = 2'b10;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

   // A load whose destination is either byte of the pointer pair overwrites
   // the pointer, so the pair update must not be issued.
   function automatic logic pair_clobbered(input logic [3:0] dest, input logic [3:0] ptr);
      logic [3:0] ptr_hi_idx;
      ptr_hi_idx = ptr + 4'd1;
      return (dest == ptr) || (dest == ptr_hi_idx);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/acknowledge memory port between the load/store unit (master)
// and the memory (slave). Signal names match the original flat ports.
interface load_store_unit_if;

   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_req;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_we, mem_req,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, mem_req,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/load_store_unit_lsu_timeout.sv
// Watchdog counter for the REQ state; only built with
// LOAD_STORE_UNIT_TIMEOUT_EN. Clears whenever run is low, so every REQ
// entry starts from zero; expired flags the 255th REQ cycle without ack.
`ifdef LOAD_STORE_UNIT_TIMEOUT_EN
module lsu_timeout
   import load_store_unit_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expired
);

   logic [7:0] cnt_q, cnt_d;

   // Count REQ cycles, restart from zero outside REQ
   always_comb begin
      cnt_d = run ? (cnt_q + 8'd1) : '0;
   end

   assign expired = run && (cnt_q == (TIMEOUT_LIMIT - 8'd1));

   // Counter register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule
`endif

// File: rtl/load_store_unit.sv
// Byte load/store sequencer between the register file and a req/ack memory
// port. Supports plain, post-increment and pre-decrement pointer modes.
// Optional watchdog: define LOAD_STORE_UNIT_TIMEOUT_EN to abort a REQ that
// sees no mem_ack within 255 cycles (err pulse); otherwise err stays 0.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     is_store,
   input  logic [1:0]               mode,
   input  logic [3:0]               ptr_sel,
   input  logic [3:0]               dest_sel,
   input  logic [7:0]               ptr_lo,
   input  logic [7:0]               ptr_hi,
   input  logic [7:0]               st_data,
   load_store_unit_if.master        mem,
   output logic [7:0]               rf_in,
   output logic [3:0]               rf_in_sel,
   output logic                     rf_write_en,
   output logic                     rf_inc,
   output logic                     rf_dec,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   logic [1:0]  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [1:0]  mode_q, mode_d;
   logic [3:0]  ptr_sel_q, ptr_sel_d;
   logic [3:0]  dest_sel_q, dest_sel_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [7:0]  rf_in_q, rf_in_d;
   logic [3:0]  rf_in_sel_q, rf_in_sel_d;
   logic        rf_write_en_q, rf_write_en_d;
   logic        rf_inc_q, rf_inc_d;
   logic        rf_dec_q, rf_dec_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        timeout_hit;
   logic        clobber;
   logic        in_wb_d;

`ifdef LOAD_STORE_UNIT_TIMEOUT_EN
   lsu_timeout u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state_q == REQ),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, command latching and registered-output decode.
   // Outputs are computed from the next state so every port comes
   // straight from a flop.
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      mode_d     = mode_q;
      ptr_sel_d  = ptr_sel_q;
      dest_sel_d = dest_sel_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rf_in_d    = '0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = REQ;
               is_store_d = is_store;
               ptr_sel_d  = ptr_sel;
               dest_sel_d = dest_sel;
               wdata_d    = st_data;
               case (mode)
                  MODE_POSTINC: mode_d = MODE_POSTINC;
                  MODE_PREDEC:  mode_d = MODE_PREDEC;
                  default:      mode_d = MODE_PLAIN;
               endcase
               addr_d = (mode == MODE_PREDEC) ? ({ptr_hi, ptr_lo} - 16'd1)
                                              : {ptr_hi, ptr_lo};
            end
         end
         REQ: begin
            if (mem.mem_ack) begin
               state_d = WB;
               if (!is_store_q) rf_in_d = mem.mem_rdata;
            end else if (timeout_hit) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         WB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_wb_d       = (state_d == WB);
      clobber       = !is_store_d && pair_clobbered(dest_sel_d, ptr_sel_d);
      req_d         = (state_d == REQ);
      we_d          = (state_d == REQ) && is_store_d;
      busy_d        = (state_d != IDLE);
      done_d        = in_wb_d;
      rf_write_en_d = in_wb_d && !is_store_d;
      rf_in_sel_d   = rf_write_en_d ? dest_sel_d : '0;
      rf_inc_d      = in_wb_d && (mode_d == MODE_POSTINC) && !clobber;
      rf_dec_d      = in_wb_d && (mode_d == MODE_PREDEC) && !clobber;
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         is_store_q    <= 1'b0;
         mode_q        <= MODE_PLAIN;
         ptr_sel_q     <= '0;
         dest_sel_q    <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         rf_in_q       <= '0;
         rf_in_sel_q   <= '0;
         rf_write_en_q <= 1'b0;
         rf_inc_q      <= 1'b0;
         rf_dec_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         is_store_q    <= is_store_d;
         mode_q        <= mode_d;
         ptr_sel_q     <= ptr_sel_d;
         dest_sel_q    <= dest_sel_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         req_q         <= req_d;
         we_q          <= we_d;
         rf_in_q       <= rf_in_d;
         rf_in_sel_q   <= rf_in_sel_d;
         rf_write_en_q <= rf_write_en_d;
         rf_inc_q      <= rf_inc_d;
         rf_dec_q      <= rf_dec_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_req   = req_q;
   assign rf_in         = rf_in_q;
   assign rf_in_sel     = rf_in_sel_q;
   assign rf_write_en   = rf_write_en_q;
   assign rf_inc        = rf_inc_q;
   assign rf_dec        = rf_dec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed and randomized commands checked
// against a transaction-level reference model of the addressing rules.
module tb_load_store_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       is_store;
   logic [1:0] mode;
   logic [3:0] ptr_sel;
   logic [3:0] dest_sel;
   logic [7:0] ptr_lo;
   logic [7:0] ptr_hi;
   logic [7:0] st_data;
   logic [7:0] rf_in;
   logic [3:0] rf_in_sel;
   logic       rf_write_en;
   logic       rf_inc;
   logic       rf_dec;
   logic       busy;
   logic       done;
   logic       err;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   load_store_unit_if mem_if ();

   load_store_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_store    (is_store),
      .mode        (mode),
      .ptr_sel     (ptr_sel),
      .dest_sel    (dest_sel),
      .ptr_lo      (ptr_lo),
      .ptr_hi      (ptr_hi),
      .st_data     (st_data),
      .mem         (mem_if),
      .rf_in       (rf_in),
      .rf_in_sel   (rf_in_sel),
      .rf_write_en (rf_write_en),
      .rf_inc      (rf_inc),
      .rf_dec      (rf_dec),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full command; expectations come from the addressing rules alone.
   task automatic do_cmd(input logic st, input logic [1:0] md, input logic [3:0] ps,
                         input logic [3:0] ds, input logic [15:0] ptr, input logic [7:0] sd,
                         input logic [7:0] rd, input int dly, input bit extra_start);
      logic [15:0] exp_addr;
      bit          clob;
      bit          exp_inc, exp_dec;

      exp_addr = (md == 2'b10) ? 16'((int'(ptr) + 65535) % 65536) : ptr;
      clob     = !st && ((ds == ps) || (int'(ds) == (int'(ps) + 1) % 16));
      exp_inc  = (md == 2'b01) && !clob;
      exp_dec  = (md == 2'b10) && !clob;

      check("idle_busy", busy, 0);
      start = 1'b1; is_store = st; mode = md; ptr_sel = ps; dest_sel = ds;
      {ptr_hi, ptr_lo} = ptr; st_data = sd;
      step();
      start = 1'b0;
      is_store = 1'($urandom); mode = 2'($urandom); ptr_sel = 4'($urandom);
      dest_sel = 4'($urandom); {ptr_hi, ptr_lo} = 16'($urandom); st_data = 8'($urandom);

      check("req_on", mem_if.mem_req, 1);
      check("addr", mem_if.mem_addr, exp_addr);
      check("we", mem_if.mem_we, st);
      if (st) check("wdata", mem_if.mem_wdata, sd);
      check("busy_req", busy, 1);

      for (int i = 0; i < dly; i++) begin
         if (extra_start && i == 0) begin
            start = 1'b1; {ptr_hi, ptr_lo} = ~ptr;
         end
         mem_if.mem_rdata = 8'($urandom);
         step();
         start = 1'b0;
         check("req_hold", mem_if.mem_req, 1);
         check("addr_hold", mem_if.mem_addr, exp_addr);
         check("done_early", done, 0);
      end

      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rd;
      step();
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 8'($urandom);

      check("wb_done", done, 1);
      check("wb_req", mem_if.mem_req, 0);
      check("wb_busy", busy, 1);
      check("wb_we", rf_write_en, !st);
      if (!st) begin
         check("wb_data", rf_in, rd);
         check("wb_sel", rf_in_sel, ds);
      end
      check("wb_inc", rf_inc, exp_inc);
      check("wb_dec", rf_dec, exp_dec);

      step();
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_we", rf_write_en, 0);
      check("post_inc", rf_inc, 0);
      check("post_dec", rf_dec, 0);
   endtask

   initial begin
      int n;
      bit err_seen;

      rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mode = '0; ptr_sel = '0;
      dest_sel = '0; ptr_lo = '0; ptr_hi = '0; st_data = '0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
      step(); step();

      check("rst_addr", mem_if.mem_addr, 0);
      check("rst_wdata", mem_if.mem_wdata, 0);
      check("rst_we", mem_if.mem_we, 0);
      check("rst_req", mem_if.mem_req, 0);
      check("rst_rf", {rf_in, rf_in_sel, rf_write_en, rf_inc, rf_dec}, 0);
      check("rst_flags", {busy, done, err}, 0);
      rst_n = 1'b1;
      step();

      // directed scenarios
      do_cmd(1'b0, 2'b00, 4'd0,  4'd3, 16'h1234, 8'h00, 8'hA5, 2, 0);
      do_cmd(1'b1, 2'b01, 4'd6,  4'd2, 16'hFFFF, 8'h5A, 8'h00, 0, 0);
      do_cmd(1'b0, 2'b10, 4'd8,  4'd1, 16'h0000, 8'h00, 8'h3C, 1, 0);
      do_cmd(1'b0, 2'b01, 4'd4,  4'd5, 16'h4000, 8'h00, 8'h77, 1, 0);
      do_cmd(1'b0, 2'b10, 4'd15, 4'd0, 16'h8001, 8'h00, 8'h11, 0, 0);
      do_cmd(1'b0, 2'b11, 4'd2,  4'd7, 16'h0100, 8'h00, 8'hC3, 1, 0);
      do_cmd(1'b1, 2'b10, 4'd9,  4'd9, 16'h0001, 8'hE7, 8'h00, 3, 0);

      // start while busy is ignored
      do_cmd(1'b0, 2'b01, 4'd10, 4'd1, 16'h2222, 8'h00, 8'h99, 2, 1);

      // stray ack in IDLE
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'hFF;
      step();
      mem_if.mem_ack = 1'b0;
      check("stray_busy", busy, 0);
      check("stray_done", done, 0);
      check("stray_req", mem_if.mem_req, 0);
      check("stray_we", rf_write_en, 0);
      step();
      check("stray_done2", done, 0);

      // reset during REQ aborts the command
      start = 1'b1; is_store = 1'b0; mode = 2'b01; ptr_sel = 4'd0; dest_sel = 4'd6;
      {ptr_hi, ptr_lo} = 16'h5555;
      step();
      start = 1'b0;
      check("abort_req_on", mem_if.mem_req, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_req", mem_if.mem_req, 0);
      check("abort_busy", busy, 0);
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h42;
      step();
      mem_if.mem_ack = 1'b0;
      check("abort_done", done, 0);
      check("abort_rf", {rf_write_en, rf_inc, rf_dec}, 0);
      step();
      check("abort_done2", done, 0);

      // missing ack
      start = 1'b1; is_store = 1'b0; mode = 2'b01; ptr_sel = 4'd0; dest_sel = 4'd6;
      {ptr_hi, ptr_lo} = 16'h0F0F;
      step();
      start = 1'b0;
`ifdef LOAD_STORE_UNIT_TIMEOUT_EN
      n = 0;
      while (n < 400 && err !== 1'b1) begin
         step();
         n++;
      end
      check("to_cycles", n, 255);
      check("to_req", mem_if.mem_req, 0);
      check("to_done", done, 0);
      check("to_rf", {rf_in, rf_in_sel, rf_write_en, rf_inc, rf_dec}, 0);
      step();
      check("to_err_pulse", err, 0);
      check("to_busy", busy, 0);
`else
      err_seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (err !== 1'b0 || mem_if.mem_req !== 1'b1) err_seen = 1'b1;
      end
      check("wait_no_err", err_seen, 0);
      check("wait_req", mem_if.mem_req, 1);
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h81;
      step();
      mem_if.mem_ack = 1'b0;
      check("wait_done", done, 1);
      check("wait_data", rf_in, 8'h81);
      step();
`endif

      // randomized commands, back-to-back
      for (int k = 0; k < 40; k++) begin
         do_cmd(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                16'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
